// File: rtl/weight_cache_pingpong_pkg.sv
// Shared types and helpers for the ping-pong weight cache: FSM state enums,
// per-bank configuration record and the word-count calculation.
package weight_cache_pingpong_pkg;

  localparam int CFG_ADDR_W = 12;
  localparam int CFG_PASS_W = 20;
  localparam int WORDS_W    = CFG_ADDR_W + 1;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_LOAD
  } fill_state_t;

  typedef enum logic {
    R_IDLE,
    R_RUN
  } rd_state_t;

  typedef struct packed {
    logic [WORDS_W-1:0]    words;
    logic [CFG_PASS_W-1:0] passes;
  } bank_cfg_t;

  // Evaluated at 64 bits so an oversized matrix is never wrapped into range.
  function automatic logic [63:0] word_count(input logic [31:0] rows,
                                             input logic [31:0] cols,
                                             input logic [31:0] bytes_per_word);
    logic [63:0] prod;
    logic [63:0] bpw;
    prod = {32'd0, rows} * {32'd0, cols};
    bpw  = {32'd0, bytes_per_word};
    return (prod + bpw - 64'd1) / bpw;
  endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// Simple dual-port weight store holding both banks; the bank select is the
// address MSB. Write-enable only, registered read with one cycle of latency.
module weight_bank_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_p1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_p1 <= mem[rd_addr];
  end

endmodule

// File: rtl/weight_cache_pingpong.sv
// Double-buffered weight cache: one bank fills from the load stream while the
// other replays to the systolic array, so consecutive layers need no load gap.
module weight_cache_pingpong
  import weight_cache_pingpong_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int BANK_DEPTH = 4096,
  parameter int ADDR_W     = CFG_ADDR_W,
  parameter int DIM_W      = 16,
  parameter int PASS_W     = CFG_PASS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  Matrix_Row,
  input  logic [DIM_W-1:0]  Matrix_Col,
  input  logic [PASS_W-1:0] OutMatrix_Row,
  input  logic              sData_valid,
  output logic              sData_ready,
  input  logic [DATA_W-1:0] sData_payload,
  input  logic              Raddr_Valid,
  output logic              mData_valid,
  output logic [DATA_W-1:0] mData_payload,
  output logic              Weight_Cached,
  output logic              Pass_Done,
  output logic [1:0]        Bank_Full,
  output logic              Cfg_Err,
  output logic              Rd_Underrun
);

  localparam int BPW = DATA_W / 8;

  fill_state_t       fill_state, fill_next;
  rd_state_t         rd_state, rd_next;
  logic              fill_sel, rd_sel;
  bank_cfg_t         cfg [2];
  bank_cfg_t         pend_cfg;
  bank_cfg_t         cfg_fill, cfg_rd;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [PASS_W-1:0] pass_cnt;

  logic [63:0] req_words;
  logic        cfg_bad;
  logic        cfg_accept, cfg_reject, fill_go, wr_en, fill_done;
  logic        rd_en, underrun, rd_release;
  logic        waddr_last, raddr_last, pass_last;
  logic [1:0]  set_mask, clr_mask;
  logic        vld_p1;
  logic [DATA_W-1:0] rd_data_p1;

  assign req_words = word_count(32'(Matrix_Row), 32'(Matrix_Col), 32'(BPW));
  assign cfg_bad   = (req_words == 64'd0) || (OutMatrix_Row == '0) ||
                     (req_words > 64'(BANK_DEPTH));

  assign cfg_fill   = cfg[fill_sel];
  assign cfg_rd     = cfg[rd_sel];
  assign waddr_last = (WORDS_W'(waddr) == cfg_fill.words - WORDS_W'(1));
  assign raddr_last = (WORDS_W'(raddr) == cfg_rd.words - WORDS_W'(1));
  assign pass_last  = (CFG_PASS_W'(pass_cnt) == cfg_rd.passes - CFG_PASS_W'(1));

  assign sData_ready = (fill_state == F_LOAD);
  assign set_mask    = {fill_done & fill_sel, fill_done & ~fill_sel};
  assign clr_mask    = {rd_release & rd_sel, rd_release & ~rd_sel};

  always_comb begin
    fill_next  = fill_state;
    cfg_accept = 1'b0;
    cfg_reject = 1'b0;
    fill_go    = 1'b0;
    wr_en      = 1'b0;
    fill_done  = 1'b0;
    case (fill_state)
      F_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_reject = 1'b1;
          end else begin
            cfg_accept = 1'b1;
            fill_next  = F_WAIT;
          end
        end
      end
      F_WAIT: begin
        if (!Bank_Full[fill_sel]) begin
          fill_go   = 1'b1;
          fill_next = F_LOAD;
        end
      end
      F_LOAD: begin
        if (sData_valid) begin
          wr_en = 1'b1;
          if (waddr_last) begin
            fill_done = 1'b1;
            fill_next = F_IDLE;
          end
        end
      end
      default: fill_next = F_IDLE;
    endcase
  end

  always_comb begin
    rd_next    = rd_state;
    rd_en      = 1'b0;
    underrun   = 1'b0;
    rd_release = 1'b0;
    case (rd_state)
      R_IDLE: begin
        underrun = Raddr_Valid;
        if (Bank_Full[rd_sel]) rd_next = R_RUN;
      end
      R_RUN: begin
        if (Raddr_Valid) begin
          rd_en = 1'b1;
          if (raddr_last && pass_last) begin
            rd_release = 1'b1;
            rd_next    = R_IDLE;
          end
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_state    <= F_IDLE;
      rd_state      <= R_IDLE;
      fill_sel      <= 1'b0;
      rd_sel        <= 1'b0;
      waddr         <= '0;
      raddr         <= '0;
      pass_cnt      <= '0;
      Bank_Full     <= 2'b00;
      Cfg_Err       <= 1'b0;
      Rd_Underrun   <= 1'b0;
      Weight_Cached <= 1'b0;
      Pass_Done     <= 1'b0;
      vld_p1        <= 1'b0;
    end else begin
      fill_state    <= fill_next;
      rd_state      <= rd_next;
      if (cfg_reject) Cfg_Err <= 1'b1;
      if (underrun) Rd_Underrun <= 1'b1;
      if (wr_en) waddr <= waddr_last ? '0 : waddr + 1'b1;
      if (fill_done) fill_sel <= ~fill_sel;
      if (rd_en) begin
        if (raddr_last) begin
          raddr    <= '0;
          pass_cnt <= pass_last ? '0 : pass_cnt + 1'b1;
        end else begin
          raddr <= raddr + 1'b1;
        end
      end
      if (rd_release) rd_sel <= ~rd_sel;
      Bank_Full     <= (Bank_Full | set_mask) & ~clr_mask;
      Weight_Cached <= (rd_next == R_RUN);
      Pass_Done     <= rd_release;
      vld_p1        <= rd_en;
    end
  end

  // A new config is parked until its bank is empty: the target bank may
  // still be replaying when start arrives, and its live config must not move.
  always_ff @(posedge clk) begin
    if (cfg_accept) begin
      pend_cfg.words  <= WORDS_W'(req_words);
      pend_cfg.passes <= CFG_PASS_W'(OutMatrix_Row);
    end
    if (fill_go) cfg[fill_sel] <= pend_cfg;
  end

  // Stage p1: registered RAM read, aligned with vld_p1 and Pass_Done.
  weight_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (2 * BANK_DEPTH),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_addr    ({fill_sel, waddr}),
    .wr_data    (sData_payload),
    .rd_en      (rd_en),
    .rd_addr    ({rd_sel, raddr}),
    .rd_data_p1 (rd_data_p1)
  );

  assign mData_valid   = vld_p1;
  assign mData_payload = vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_weight_cache_pingpong.sv
// Scoreboard bench for the ping-pong weight cache: every read request pushes
// its expected word and release flag, the monitor pops on each returned word.
module tb_weight_cache_pingpong;

  localparam int DATA_W = 64;
  localparam int DIM_W  = 16;
  localparam int PASS_W = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  Matrix_Row = '0;
  logic [DIM_W-1:0]  Matrix_Col = '0;
  logic [PASS_W-1:0] OutMatrix_Row = '0;
  logic              sData_valid = 1'b0;
  logic              sData_ready;
  logic [DATA_W-1:0] sData_payload = '0;
  logic              Raddr_Valid = 1'b0;
  logic              mData_valid;
  logic [DATA_W-1:0] mData_payload;
  logic              Weight_Cached;
  logic              Pass_Done;
  logic [1:0]        Bank_Full;
  logic              Cfg_Err;
  logic              Rd_Underrun;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   pd_count = 0;

  always #5 clk = ~clk;

  weight_cache_pingpong dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .Matrix_Row    (Matrix_Row),
    .Matrix_Col    (Matrix_Col),
    .OutMatrix_Row (OutMatrix_Row),
    .sData_valid   (sData_valid),
    .sData_ready   (sData_ready),
    .sData_payload (sData_payload),
    .Raddr_Valid   (Raddr_Valid),
    .mData_valid   (mData_valid),
    .mData_payload (mData_payload),
    .Weight_Cached (Weight_Cached),
    .Pass_Done     (Pass_Done),
    .Bank_Full     (Bank_Full),
    .Cfg_Err       (Cfg_Err),
    .Rd_Underrun   (Rd_Underrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mkword(input logic [15:0] tag, input int i);
    return {tag, 16'h0000, 32'(i)};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (Pass_Done) pd_count++;
      if (mData_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_valid", 64'(mData_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rd_data", mData_payload, mon_e.data);
          chk("pass_done", 64'(Pass_Done), 64'(mon_e.last));
        end
      end else if (Pass_Done) begin
        chk("stray_pass_done", 64'(Pass_Done), 64'd0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    sData_valid = 1'b0;
    Raddr_Valid = 1'b0;
    tick();
    chk("rst_ready", 64'(sData_ready), 64'd0);
    chk("rst_mvalid", 64'(mData_valid), 64'd0);
    chk("rst_payload", mData_payload, 64'd0);
    chk("rst_cached", 64'(Weight_Cached), 64'd0);
    chk("rst_pass_done", 64'(Pass_Done), 64'd0);
    chk("rst_bank_full", 64'(Bank_Full), 64'd0);
    chk("rst_cfg_err", 64'(Cfg_Err), 64'd0);
    chk("rst_underrun", 64'(Rd_Underrun), 64'd0);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic start_cfg(input int rows, input int cols, input int passes);
    Matrix_Row    = DIM_W'(rows);
    Matrix_Col    = DIM_W'(cols);
    OutMatrix_Row = PASS_W'(passes);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [15:0] tag, input bit gaps);
    int i = 0;
    int budget = 0;
    bit v;
    bit fire;
    while (i < n && budget < 20000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      sData_valid   = v;
      sData_payload = mkword(tag, i);
      fire = v && sData_ready;
      tick();
      if (fire) i++;
      budget++;
    end
    sData_valid = 1'b0;
    chk("load_beats", 64'(i), 64'(n));
  endtask

  task automatic read_beats(input int words, input int passes, input logic [15:0] tag,
                            input int stop_after);
    int   total;
    int   n;
    exp_t e;
    total = words * passes;
    n = (stop_after > 0) ? stop_after : total;
    for (int k = 0; k < n; k++) begin
      Raddr_Valid = 1'b1;
      e.data = mkword(tag, k % words);
      e.last = (k == total - 1);
      sb.push_back(e);
      tick();
    end
    Raddr_Valid = 1'b0;
  endtask

  task automatic wait_cached(input int bound);
    int c = 0;
    while (!Weight_Cached && c < bound) begin
      tick();
      c++;
    end
    chk("cached", 64'(Weight_Cached), 64'd1);
  endtask

  task automatic run_basic();
    int pd0;
    do_reset();
    start_cfg(288, 32, 3);
    load_words(1152, 16'h0000, 1'b0);
    chk("s1_bank_full", 64'(Bank_Full), 64'd1);
    wait_cached(4);
    pd0 = pd_count;
    read_beats(1152, 3, 16'h0000, 0);
    chk("s1_pass_done", 64'(Pass_Done), 64'd1);
    chk("s1_full_clr", 64'(Bank_Full), 64'd0);
    chk("s1_cached_drop", 64'(Weight_Cached), 64'd0);
    tick();
    chk("s1_pd_pulse", 64'(Pass_Done), 64'd0);
    chk("s1_pd_once", 64'(pd_count - pd0), 64'd1);
  endtask

  initial begin
    run_basic();

    // Ping-pong: B fills during A's replay, C parks until A's bank frees up.
    do_reset();
    start_cfg(288, 32, 1);
    load_words(1152, 16'h00AA, 1'b0);
    wait_cached(4);
    fork
      read_beats(1152, 1, 16'h00AA, 0);
      begin
        start_cfg(64, 16, 2);
        chk("s2_wait_state", 64'(sData_ready), 64'd0);
        tick();
        chk("s2_no_wait", 64'(sData_ready), 64'd1);
        load_words(128, 16'h00BB, 1'b0);
        chk("s2_both_full", 64'(Bank_Full), 64'd3);
        start_cfg(10, 10, 1);
        repeat (3) begin
          tick();
          chk("s3_held", 64'(sData_ready), 64'd0);
        end
      end
    join
    chk("s2_pass_done", 64'(Pass_Done), 64'd1);
    chk("s2_cached_gap", 64'(Weight_Cached), 64'd0);
    chk("s3_ready_gap", 64'(sData_ready), 64'd0);
    chk("s2_full_10", 64'(Bank_Full), 64'd2);
    tick();
    chk("s2_cached_back", 64'(Weight_Cached), 64'd1);
    chk("s3_ready_up", 64'(sData_ready), 64'd1);
    fork
      load_words(13, 16'h00CC, 1'b0);
      read_beats(128, 2, 16'h00BB, 0);
    join
    chk("s3_full_01", 64'(Bank_Full), 64'd1);
    wait_cached(4);
    read_beats(13, 1, 16'h00CC, 0);
    chk("s3_full_clr", 64'(Bank_Full), 64'd0);

    // Configuration errors and the exact-capacity boundary.
    do_reset();
    start_cfg(0, 32, 1);
    chk("err_row0", 64'(Cfg_Err), 64'd1);
    tick();
    chk("err_row0_ready", 64'(sData_ready), 64'd0);
    chk("err_row0_full", 64'(Bank_Full), 64'd0);
    do_reset();
    start_cfg(512, 128, 1);
    chk("err_too_big", 64'(Cfg_Err), 64'd1);
    tick();
    chk("err_too_big_ready", 64'(sData_ready), 64'd0);
    start_cfg(8, 8, 1);
    tick();
    chk("err_sticky", 64'(Cfg_Err), 64'd1);
    do_reset();
    start_cfg(32, 32, 0);
    chk("err_pass0", 64'(Cfg_Err), 64'd1);
    do_reset();
    start_cfg(256, 128, 1);
    chk("cap_exact_ok", 64'(Cfg_Err), 64'd0);
    tick();
    chk("cap_exact_ready", 64'(sData_ready), 64'd1);

    // Underrun before any load, then a gappy stream.
    do_reset();
    Raddr_Valid = 1'b1;
    tick();
    Raddr_Valid = 1'b0;
    chk("underrun", 64'(Rd_Underrun), 64'd1);
    chk("underrun_no_data", 64'(mData_valid), 64'd0);
    start_cfg(64, 16, 1);
    load_words(128, 16'h0055, 1'b1);
    wait_cached(4);
    read_beats(128, 1, 16'h0055, 0);
    tick();
    chk("underrun_sticky", 64'(Rd_Underrun), 64'd1);

    // Reset mid-load and mid-replay, then a clean full run.
    do_reset();
    start_cfg(288, 32, 3);
    load_words(500, 16'h0066, 1'b0);
    do_reset();
    start_cfg(288, 32, 3);
    load_words(1152, 16'h0066, 1'b0);
    wait_cached(4);
    read_beats(1152, 3, 16'h0066, 600);
    do_reset();
    run_basic();

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_cache_pingpong.md
Name: weight_cache_pingpong

Overview:
- Double-buffered successor to the single-bank weight cache that feeds the systolic array.
- Loads one layer's weight matrix from a 64-bit-class stream into one of two banks while the other bank is replayed to the array on Img2Col read requests.
- Weights for the next layer are therefore cached with no load bubble between layers.
- Replay count, matrix size and word width are parametrised, and each bank holds its own configuration.

Parameters:
- DATA_W, 64, payload width in bits; must be a multiple of 8 (int8 weights; DATA_W/8 weights per word).
- BANK_DEPTH, 4096, words per bank.
- ADDR_W, 12, log2(BANK_DEPTH).
- DIM_W, 16, width of the Matrix_Row and Matrix_Col fields.
- PASS_W, 20, width of OutMatrix_Row, the replay pass count.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches the load configuration.
- Matrix_Row  in  DIM_W  weight matrix rows.
- Matrix_Col  in  DIM_W  weight matrix cols.
- OutMatrix_Row  in  PASS_W  number of full replays of the bank before release.
- sData_valid  in  1  load stream valid.
- sData_ready  out  1  load stream ready.
- sData_payload  in  DATA_W  weight word.
- Raddr_Valid  in  1  read request, one word per cycle.
- mData_valid  out  1  read data valid.
- mData_payload  out  DATA_W  read word.
- Weight_Cached  out  1  a bank is loaded and selected for reading.
- Pass_Done  out  1  one-cycle pulse when the read bank is released.
- Bank_Full  out  2  per-bank full flags.
- Cfg_Err  out  1  sticky flag; cleared only by reset.
- Rd_Underrun  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high, clk only): all outputs 0; fill_sel=0, rd_sel=0; both banks empty; FSMs idle. Reset mid-load or mid-replay discards all contents; no Pass_Done pulse is emitted.
- Word count: words = ceil(Matrix_Row*Matrix_Col/(DATA_W/8)), computed at full product width with no truncation.
- Fill FSM, states F_IDLE, F_WAIT, F_LOAD:
  - start is accepted only in F_IDLE.
  - If words==0, OutMatrix_Row==0, or words>BANK_DEPTH: set Cfg_Err and ignore the start.
  - Otherwise latch words and passes into the per-bank config of fill_sel, then go to F_WAIT.
  - start seen in F_WAIT or F_LOAD is ignored; no error is raised.
  - F_WAIT -> F_LOAD when Bank_Full[fill_sel]==0, in the same cycle that condition holds.
  - F_LOAD: sData_ready=1. Each valid&&ready beat writes address waddr (0 to words-1) in bank fill_sel.
  - On the beat that writes words-1: set Bank_Full[fill_sel], toggle fill_sel, return to F_IDLE.
  - sData_ready is 0 in all other states.
- Read FSM, states R_IDLE, R_RUN:
  - R_IDLE -> R_RUN when Bank_Full[rd_sel]. Weight_Cached=1 throughout R_RUN (registered; rises the cycle after entry).
  - In R_RUN, each Raddr_Valid reads raddr of bank rd_sel.
  - Read latency is 1 cycle: mData_valid and mData_payload follow Raddr_Valid by exactly one clk. There is no backpressure.
  - raddr wraps from words-1 to 0 and increments pass_cnt.
  - On the read of the last word of pass OutMatrix_Row-1:
    - clear Bank_Full[rd_sel] and toggle rd_sel;
    - pulse Pass_Done (in the same cycle as that last mData_valid);
    - drop Weight_Cached and return to R_IDLE.
- Raddr_Valid in R_IDLE: no read is issued, mData_valid stays 0, Rd_Underrun is set.
- Simultaneous events:
  - A fill completion and a read release on different banks in the same cycle are both applied.
  - A bank cleared by a read release in cycle N may enter F_LOAD in cycle N+1.
  - A bank set full in cycle N may enter R_RUN in cycle N+1.
- Zero-bubble handoff: if the other bank is already full at Pass_Done, Weight_Cached drops for exactly 1 cycle, then reasserts.
- Config, counters and flags are registered; there is no combinational path from sData_valid to sData_ready.

Decomposition:
- Shared package:
  - fill and read state enums;
  - per-bank config struct {words: ADDR_W+1 bits, passes: PASS_W bits};
  - word-count function ceil(row*col/bytes_per_word).
- Sub-module weight_bank_ram:
  - simple dual-port, depth 2*BANK_DEPTH, DATA_W wide, address = {bank bit, word addr};
  - write port: write-enable only; read port: registered, 1-cycle latency.
- Top: the two FSMs, per-bank config registers and error flags.

Test Plan:
- Load 288x32 (1152 words), OutMatrix_Row=3, stream word i = i -> Bank_Full=01, Weight_Cached=1. 3456 Raddr_Valid beats return 0..1151 three times. Pass_Done pulses once, on beat 3456; Bank_Full then returns to 00.
- Load A (288x32) then B (64x16, 128 words) back-to-back while A replays -> B is accepted without waiting and Bank_Full=11. At A's Pass_Done, Weight_Cached is low for 1 cycle, then B's words 0..127 are returned.
- Third start while both banks are full -> fill waits in F_WAIT with sData_ready=0. Load proceeds into bank 0 the cycle after bank 0's Pass_Done.
- Start with Matrix_Row=0, then with 512x128 (8192 words > 4096) -> Cfg_Err=1, no state change, sData_ready stays 0.
- Raddr_Valid before any load -> Rd_Underrun=1, mData_valid=0. Random sData_valid gaps (50% duty) -> data still returned in order, with no lost or duplicated words.
- Assert reset at word 500 of the load and again mid-replay -> all outputs 0 next cycle. A fresh 1152-word load afterwards passes the first scenario.
